// File: rtl/halfadder_pulse_sequencer.sv
// Bit-serial sequencer for a pulse-driven half-adder cell.
// Drives a/b/clk pulses per bit and gathers s/cout pulses into words.
module halfadder_pulse_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 3,
  parameter int CAPT_CYC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ha_a,
  output logic             ha_b,
  output logic             ha_clk,
  input  logic             ha_s,
  input  logic             ha_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic [WIDTH-1:0] out_c,
  output logic             busy,
  output logic             stray
);
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CMAX = (SETUP_CYC > CAPT_CYC) ? SETUP_CYC : CAPT_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    IDLE, DRIVE, SETUP, CLOCK, CAPTURE, DONE
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_lat, b_lat;
  logic              accept, last_bit;
  logic              setup_end, capt_end;
  logic              drv_a, drv_b;

  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign accept    = in_valid && in_ready;
  assign last_bit  = idx == IW'(WIDTH - 1);
  assign setup_end = cnt == CW'(SETUP_CYC - 1);
  assign capt_end  = cnt == CW'(CAPT_CYC - 1);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = DRIVE;
          idx_n   = '0;
        end
      end
      DRIVE: state_n = SETUP;
      SETUP: begin
        if (setup_end) state_n = CLOCK;
      end
      CLOCK: state_n = CAPTURE;
      CAPTURE: begin
        if (capt_end) begin
          if (last_bit) begin
            state_n = DONE;
          end else begin
            state_n = DRIVE;
            idx_n   = idx + 1'b1;
          end
        end
      end
      DONE: begin
        if (out_valid && out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // pulses are registered, so they are computed from the next state
  always_comb begin
    drv_a = 1'b0;
    drv_b = 1'b0;
    if (state_n == DRIVE) begin
      drv_a = accept ? in_a[idx_n] : a_lat[idx_n];
      drv_b = accept ? in_b[idx_n] : b_lat[idx_n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      ha_a      <= 1'b0;
      ha_b      <= 1'b0;
      ha_clk    <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= '0;
      out_c     <= '0;
      stray     <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      ha_a   <= drv_a;
      ha_b   <= drv_b;
      ha_clk <= state_n == CLOCK;
      if (state_n != state) begin
        cnt <= '0;
      end else if (state == SETUP || state == CAPTURE) begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        a_lat <= in_a;
        b_lat <= in_b;
        out_s <= '0;
        out_c <= '0;
        stray <= 1'b0;
      end else begin
        if (state == CAPTURE) begin
          out_s[idx] <= out_s[idx] | ha_s;
          out_c[idx] <= out_c[idx] | ha_cout;
        end
        if (state != CAPTURE && (ha_s || ha_cout)) stray <= 1'b1;
      end
      // valid rises one cycle into DONE and drops after the handshake
      if (state == DONE) out_valid <= !(out_valid && out_ready);
    end
  end
endmodule
